// File: rtl/apb_reg_decoder_if.sv
// APB3 completer-side bus bundle for the register decoder.
// The master modport drives requests; the slave modport answers them.
interface apb_reg_decoder_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_reg_decoder.sv
// APB3 slave front-end: phase tracking with wait states, one-hot register decode,
// read-data return, error flagging and a keyed multi-cycle software reset pulse.
module apb_reg_decoder #(
   parameter int                    ADDR_WIDTH  = 12,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] SW_RST_ADDR = 12'hFFC,
   parameter logic [DATA_WIDTH-1:0] SW_RST_KEY  = 32'hA5A50001,
   parameter int                    SW_RST_LEN  = 4
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb_reg_decoder_if.slave      apb,
   output logic [NUM_REGS-1:0]   reg_en,
   output logic                  reg_write,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  sw_rst
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   localparam int                  IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int                  CNT_W = $clog2(SW_RST_LEN + 1);
   localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(4 * NUM_REGS);

   logic [0:0]            state_q, state_d;
   logic [3:0]            wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [CNT_W-1:0]      rst_cnt_q, rst_cnt_d;

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic                  hit;
   logic                  sw_hit;
   logic                  complete;

   // Decode always works on the address captured in SETUP, never the live bus.
   always_comb begin
      offset = addr_q - BASE_ADDR;
      hit    = (addr_q[1:0] == 2'b00) && (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
      idx    = offset[IDX_W+1:2];
      sw_hit = (addr_q == SW_RST_ADDR);
   end

   assign complete = (state_q == ACCESS) && apb.PSEL && apb.PENABLE && (wait_q == 4'd0);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      write_d = write_q;
      case (state_q)
         IDLE: begin
            if (apb.PSEL && !apb.PENABLE) begin
               state_d = ACCESS;
               addr_d  = apb.PADDR;
               write_d = apb.PWRITE;
               wait_d  = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (!apb.PSEL) begin
               state_d = IDLE;
            end else if (apb.PENABLE) begin
               if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
               else                state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A key write reloads the counter even while a pulse is already running.
   always_comb begin
      rst_cnt_d = rst_cnt_q;
      if (complete && write_q && sw_hit && (apb.PWDATA == SW_RST_KEY))
         rst_cnt_d = CNT_W'(SW_RST_LEN);
      else if (rst_cnt_q != '0)
         rst_cnt_d = rst_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         wait_q    <= 4'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         rst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         rst_cnt_q <= rst_cnt_d;
      end
   end

   always_comb begin
      reg_en = '0;
      for (int i = 0; i < NUM_REGS; i++)
         reg_en[i] = complete && hit && (idx == IDX_W'(i));
   end

   assign apb.PREADY  = complete;
   assign apb.PSLVERR = complete && !hit && !sw_hit;
   assign apb.PRDATA  = (complete && !write_q && hit) ? reg_rdata : '0;
   assign reg_write   = write_q;
   assign reg_wdata   = apb.PWDATA;
   assign sw_rst      = (rst_cnt_q != '0);
endmodule

// File: tb/tb_apb_reg_decoder.sv
// Directed bench for apb_reg_decoder: three instances (0, 2 and 3 wait states) share
// one APB driver; expected completions go through a scoreboard queue.
module tb_apb_reg_decoder;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NR = 8;

   typedef struct {
      logic [NR-1:0] en;
      logic          err;
      logic [DW-1:0] rd;
      int            waits;
      logic          wr;
      logic [DW-1:0] wd;
   } exp_t;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] field_rd;
   logic [1:0]    sel;

   exp_t sbq[$];
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   always #5 PCLK = ~PCLK;

   apb_reg_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
   apb_reg_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
   apb_reg_decoder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

   assign bus0.PSEL = psel && (sel == 2'd0);
   assign bus2.PSEL = psel && (sel == 2'd1);
   assign bus3.PSEL = psel && (sel == 2'd2);
   assign bus0.PENABLE = penable;
   assign bus2.PENABLE = penable;
   assign bus3.PENABLE = penable;
   assign bus0.PWRITE = pwrite;
   assign bus2.PWRITE = pwrite;
   assign bus3.PWRITE = pwrite;
   assign bus0.PADDR = paddr;
   assign bus2.PADDR = paddr;
   assign bus3.PADDR = paddr;
   assign bus0.PWDATA = pwdata;
   assign bus2.PWDATA = pwdata;
   assign bus3.PWDATA = pwdata;

   logic [NR-1:0] en0, en2, en3;
   logic          wr0, wr2, wr3;
   logic [DW-1:0] wd0, wd2, wd3;
   logic [DW-1:0] rd0, rd2, rd3;
   logic          sw0, sw2, sw3;

   // Field model: a field drives its read bus only while its enable is high.
   assign rd0 = (|en0) ? field_rd : '0;
   assign rd2 = (|en2) ? field_rd : '0;
   assign rd3 = (|en3) ? field_rd : '0;

   apb_reg_decoder #(.WAIT_STATES(0)) dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0), .reg_en(en0), .reg_write(wr0),
      .reg_wdata(wd0), .reg_rdata(rd0), .sw_rst(sw0));
   apb_reg_decoder #(.WAIT_STATES(2)) dut2 (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus2), .reg_en(en2), .reg_write(wr2),
      .reg_wdata(wd2), .reg_rdata(rd2), .sw_rst(sw2));
   apb_reg_decoder #(.WAIT_STATES(3)) dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus3), .reg_en(en3), .reg_write(wr3),
      .reg_wdata(wd3), .reg_rdata(rd3), .sw_rst(sw3));

   logic          o_ready, o_err, o_wr, o_sw;
   logic [NR-1:0] o_en;
   logic [DW-1:0] o_rd, o_wd;

   always_comb begin
      o_ready = bus0.PREADY; o_err = bus0.PSLVERR; o_rd = bus0.PRDATA;
      o_en = en0; o_wr = wr0; o_wd = wd0; o_sw = sw0;
      if (sel == 2'd1) begin
         o_ready = bus2.PREADY; o_err = bus2.PSLVERR; o_rd = bus2.PRDATA;
         o_en = en2; o_wr = wr2; o_wd = wd2; o_sw = sw2;
      end else if (sel == 2'd2) begin
         o_ready = bus3.PREADY; o_err = bus3.PSLVERR; o_rd = bus3.PRDATA;
         o_en = en3; o_wr = wr3; o_wd = wd3; o_sw = sw3;
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input bit done, input int waits, input logic [NR-1:0] en,
                              input logic err, input logic [DW-1:0] rd, input logic wr,
                              input logic [DW-1:0] wd);
      exp_t e;
      e = sbq.pop_front();
      checkVal("completed", {63'd0, done}, 64'd1);
      checkVal("wait_cycles", 64'(waits), 64'(e.waits));
      checkVal("reg_en", 64'(en), 64'(e.en));
      checkVal("pslverr", 64'(err), 64'(e.err));
      checkVal("prdata", 64'(rd), 64'(e.rd));
      checkVal("reg_write", 64'(wr), 64'(e.wr));
      checkVal("reg_wdata", 64'(wd), 64'(e.wd));
   endtask

   logic compl_sw;

   // One full SETUP/ACCESS transfer; PADDR is scrambled during ACCESS on purpose.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr,
                                input logic [DW-1:0] data, input logic [NR-1:0] exp_en,
                                input logic exp_err, input logic [DW-1:0] exp_rd,
                                input int exp_waits);
      exp_t          e;
      int            waits;
      bit            done;
      logic [NR-1:0] c_en;
      logic          c_err, c_wr;
      logic [DW-1:0] c_rd, c_wd;
      e.en = exp_en; e.err = exp_err; e.rd = exp_rd; e.waits = exp_waits;
      e.wr = wr; e.wd = data;
      sbq.push_back(e);
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
      @(posedge PCLK); #1;
      penable = 1'b1; paddr = addr ^ 12'h55C;
      waits = 0; done = 1'b0;
      c_en = '0; c_err = 1'b0; c_rd = '0; c_wr = 1'b0; c_wd = '0; compl_sw = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge PCLK);
         if (o_ready === 1'b1) begin
            done = 1'b1;
            c_en = o_en; c_err = o_err; c_rd = o_rd; c_wr = o_wr; c_wd = o_wd;
            compl_sw = o_sw;
         end else begin
            waits++;
            checkVal("wait_reg_en", 64'(o_en), 64'd0);
         end
      end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge PCLK);
      checkVal("post_pready", 64'(o_ready), 64'd0);
      checkVal("post_reg_en", 64'(o_en), 64'd0);
      checkVal("post_prdata", 64'(o_rd), 64'd0);
      checkOutput(done, waits, c_en, c_err, c_rd, c_wr, c_wd);
   endtask

   task automatic countPulse(output int len);
      len = 0;
      while (o_sw === 1'b1 && len < 30) begin
         len++;
         @(negedge PCLK);
      end
   endtask

   int plen;

   initial begin
      PRESETn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; field_rd = '0; sel = 2'd0;
      #3;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         checkVal("rst_pready", 64'(o_ready), 64'd0);
         checkVal("rst_pslverr", 64'(o_err), 64'd0);
         checkVal("rst_prdata", 64'(o_rd), 64'd0);
         checkVal("rst_reg_en", 64'(o_en), 64'd0);
         checkVal("rst_sw_rst", 64'(o_sw), 64'd0);
      end
      sel = 2'd0;
      @(posedge PCLK); #1 PRESETn = 1'b1;

      $display("[TB] zero-wait decode");
      applyStimulus(12'h004, 1'b1, 32'h0000_1234, 8'b0000_0010, 1'b0, 32'h0, 0);
      field_rd = 32'h1111_2222;
      applyStimulus(12'h000, 1'b0, 32'h0, 8'b0000_0001, 1'b0, 32'h1111_2222, 0);
      applyStimulus(12'h01C, 1'b1, 32'hBEEF_0007, 8'b1000_0000, 1'b0, 32'h0, 0);

      $display("[TB] two wait states");
      sel = 2'd1; field_rd = 32'h0000_CAFE;
      applyStimulus(12'h01C, 1'b0, 32'h0, 8'h80, 1'b0, 32'h0000_CAFE, 2);

      $display("[TB] error accesses");
      sel = 2'd0; field_rd = 32'h5A5A_5A5A;
      applyStimulus(12'h020, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0, 0);
      applyStimulus(12'h006, 1'b1, 32'h0000_00AA, 8'h00, 1'b1, 32'h0, 0);

      $display("[TB] software reset");
      applyStimulus(12'hFFC, 1'b1, 32'hA5A5_0001, 8'h00, 1'b0, 32'h0, 0);
      checkVal("sw_rst_in_completion", 64'(compl_sw), 64'd0);
      countPulse(plen);
      checkVal("sw_rst_len", 64'(plen), 64'd4);
      applyStimulus(12'hFFC, 1'b1, 32'h0000_0000, 8'h00, 1'b0, 32'h0, 0);
      countPulse(plen);
      checkVal("sw_rst_wrong_key", 64'(plen), 64'd0);
      applyStimulus(12'hFFC, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 0);

      applyStimulus(12'hFFC, 1'b1, 32'hA5A5_0001, 8'h00, 1'b0, 32'h0, 0);
      checkVal("sw_rst_cycle1", 64'(o_sw), 64'd1);
      applyStimulus(12'hFFC, 1'b1, 32'hA5A5_0001, 8'h00, 1'b0, 32'h0, 0);
      checkVal("sw_rst_cycle3", 64'(compl_sw), 64'd1);
      countPulse(plen);
      checkVal("sw_rst_rekey_len", 64'(plen), 64'd4);

      applyStimulus(12'hFFC, 1'b1, 32'hA5A5_0001, 8'h00, 1'b0, 32'h0, 0);
      checkVal("sw_rst_before_reset", 64'(o_sw), 64'd1);
      #2 PRESETn = 1'b0;
      #1;
      checkVal("sw_rst_async_drop", 64'(o_sw), 64'd0);
      checkVal("reset_pready", 64'(o_ready), 64'd0);
      @(posedge PCLK); #1 PRESETn = 1'b1;
      @(negedge PCLK);
      checkVal("sw_rst_cancelled", 64'(o_sw), 64'd0);

      $display("[TB] abort with three wait states");
      sel = 2'd2; field_rd = 32'h0000_0808;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b0;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      checkVal("abort_access1_pready", 64'(o_ready), 64'd0);
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge PCLK);
         checkVal("abort_pready", 64'(o_ready), 64'd0);
         checkVal("abort_reg_en", 64'(o_en), 64'd0);
      end
      applyStimulus(12'h008, 1'b0, 32'h0, 8'h04, 1'b0, 32'h0000_0808, 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
